counter4b_checker: RTL and testbench
====================================

# counter4b_checker

Sequence checker for the free-running 4-bit counter. It samples the counter outputs Qa..Qd and Rc every clock and confirms that the value advances by exactly one modulo 16, with Rc high only at terminal count. It reports lock, one-cycle error pulses, a saturating error count and a wrap count. It sits beside the counter on the same clk, as the consuming end of its output interface, in both board builds and simulation.

## Interface
Parameters:
- LOCK_N, 4: consecutive good transitions needed to declare lock (legal range 1..15).
- ERR_W, 8: width of err_cnt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- Qa  in  1  counter bit 0 (LSB).
- Qb  in  1  counter bit 1.
- Qc  in  1  counter bit 2.
- Qd  in  1  counter bit 3 (MSB).
- Rc  in  1  counter ripple carry; legal only when {Qd,Qc,Qb,Qa} == 4'hF.
- locked  out  1  high while the sequence is verified.
- err  out  1  one-cycle pulse on a detected fault while locked.
- err_cnt  out  ERR_W  faults detected while locked; saturates at all-ones.
- wrap_cnt  out  8  15->0 transitions seen while locked; wraps mod 256.
- q_seen  out  4  last sampled value, {Qd,Qc,Qb,Qa}.

## Operation
- Each edge: q = {Qd,Qc,Qb,Qa}. q_seen <= q.
- Step check against the previous sample p (held in q_seen):
  - step_ok = (q == p + 1 mod 16).
  - rc_ok = (Rc == (q == 4'hF)).
  - good = step_ok && rc_ok.
- States:
  - IDLE: no previous sample exists. On the next edge, capture q and go to ACQ with good_cnt = 0. No checking happens in IDLE.
  - ACQ: a good transition increments good_cnt. A bad transition clears good_cnt but does not raise err or increment err_cnt. When good_cnt reaches LOCK_N, go to LOCKED.
  - LOCKED: a good transition stays in LOCKED. A bad transition:
    - err pulses;
    - err_cnt increments, saturating;
    - state goes to ACQ with good_cnt = 0.
- A stall, where q repeats, is a fault: the counter has no enable.
- A step fault and an Rc fault in the same cycle count as one fault.
- wrap_cnt increments when, while in LOCKED, p == 4'hF, q == 4'h0 and the transition is good.
- locked = (state == LOCKED), driven from a register.
- good_cnt is 4 bits wide.

## Timing
- All outputs are registered. Response latency is one edge: a value sampled at edge k is reflected in the outputs after edge k.
- Lock timing after reset release:
  - edge 1: IDLE->ACQ;
  - edges 2..LOCK_N+1: good transitions;
  - locked is high after edge LOCK_N+1 (edge 5 with default LOCK_N = 4).
- err is high for exactly one cycle per fault. locked falls on the same edge that err rises.
- Relock after a fault: the faulty sample becomes p, and locked returns after LOCK_N further good edges.
- Reset values: state IDLE, locked 0, err 0, err_cnt 0, wrap_cnt 0, q_seen 0, good_cnt 0.
- Reset has priority over every event, including reset asserted mid-lock or during a fault cycle. Counters are cleared, not held.
- err_cnt at all-ones stays at all-ones, and err still pulses.
- wrap_cnt at 255 wraps to 0 on the next wrap.

## Test plan
- Clean run: rst for 2 cycles, counter free-running from 0 (period 20 ns).
  - Required: locked rises after the 5th edge post-reset, err stays 0 throughout.
  - Required: after 64 further edges, wrap_cnt = 4 and err_cnt = 0.
- Skip while locked: force q from 5 to 7.
  - Required: err = 1 for one cycle, err_cnt = 1, locked = 0.
  - Required: locked returns after 4 good edges (8, 9, 10, 11).
- Rc stuck at 0 while locked.
  - Required: a fault at each q = 15 sample; err_cnt increments once per 16 cycles.
  - Required: wrap_cnt does not increment, since the 15->0 transition is sampled in ACQ.
- Stall and noise in ACQ: hold q at 3 for 3 cycles before lock.
  - Required: err = 0, err_cnt = 0, good_cnt restarts.
  - Required: locked rises 4 edges after stepping resumes.
- Saturation with ERR_W = 2: repeat 5 cycles of (lock, inject skip).
  - Required: err_cnt reads 1, 2, 3, 3, 3, and err pulses every time.
- Reset mid-lock: assert rst for one cycle while locked, with wrap_cnt = 2 and err_cnt = 1.
  - Required: the next cycle shows all outputs 0 and state IDLE.
  - Required: relock 5 edges after rst falls.

Source files
------------

// File: rtl/counter4b_checker.sv
// counter4b_checker: sequence checker for a free-running 4-bit counter.
// Samples {Qd,Qc,Qb,Qa} and Rc every rising edge and checks two things: the
// value advances by exactly one modulo 16, and Rc is high only at terminal
// count. It declares lock after LOCK_N consecutive good transitions. While
// locked, it reports faults and counts wraps.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   Qa..Qd    counter bits, Qa is the LSB
//   Rc        counter ripple carry
//   locked    high while the sequence is verified
//   err       one-cycle pulse per fault detected while locked
//   err_cnt   faults seen while locked, saturating at all-ones
//   wrap_cnt  good 15->0 transitions seen while locked, modulo 256
//   q_seen    last sampled counter value
module counter4b_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Qa,
  input  logic             Qb,
  input  logic             Qc,
  input  logic             Qd,
  input  logic             Rc,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       wrap_cnt,
  output logic [3:0]       q_seen
);

  typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

  state_e           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       q_seen_q, q_seen_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;

  logic [3:0] q;
  logic [3:0] good_inc;
  logic       step_ok;
  logic       rc_ok;
  logic       good;

  assign q        = {Qd, Qc, Qb, Qa};
  assign step_ok  = (q == 4'(q_seen_q + 4'd1));
  assign rc_ok    = (Rc == (q == 4'hF));
  // A step fault and an Rc fault in the same cycle collapse into one fault.
  assign good     = step_ok && rc_ok;
  assign good_inc = good_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = 1'b0;
    q_seen_d   = q;

    unique case (state_q)
      StIdle: begin
        // No previous sample yet, so nothing to check this edge.
        state_d    = StAcq;
        good_cnt_d = 4'd0;
      end
      StAcq: begin
        if (good) begin
          if (good_inc == 4'(LOCK_N)) begin
            state_d    = StLocked;
            good_cnt_d = 4'd0;
          end else begin
            good_cnt_d = good_inc;
          end
        end else begin
          // Faults before lock only restart acquisition.
          good_cnt_d = 4'd0;
        end
      end
      StLocked: begin
        if (good) begin
          if (q_seen_q == 4'hF && q == 4'h0) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
          end
        end else begin
          err_d      = 1'b1;
          state_d    = StAcq;
          good_cnt_d = 4'd0;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
      end
      default: begin
        state_d    = StIdle;
        good_cnt_d = 4'd0;
      end
    endcase

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      good_cnt_q <= 4'd0;
      q_seen_q   <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      q_seen_q   <= q_seen_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign q_seen   = q_seen_q;

endmodule

// File: tb/tb_counter4b_checker.sv
// Bench for counter4b_checker. Two instances share one stimulus stream: the
// default build (ERR_W = 8) and a narrow build (ERR_W = 2) for saturation.
// Each driven cycle pushes the expected outputs to a queue. A monitor pops
// them just after the edge and compares.
module tb_counter4b_checker;

  localparam int LockN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       qa = 1'b0, qb = 1'b0, qc = 1'b0, qd = 1'b0, rc = 1'b0;
  logic       locked, err, locked_s, err_s;
  logic [7:0] err_cnt, wrap_cnt, wrap_cnt_s;
  logic [1:0] err_cnt_s;
  logic [3:0] q_seen, q_seen_s;

  always #10 clk = ~clk;

  counter4b_checker #(.LOCK_N(LockN), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .Qa(qa), .Qb(qb), .Qc(qc), .Qd(qd), .Rc(rc),
    .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .q_seen(q_seen)
  );

  counter4b_checker #(.LOCK_N(LockN), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Qa(qa), .Qb(qb), .Qc(qc), .Qd(qd), .Rc(rc),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s), .wrap_cnt(wrap_cnt_s),
    .q_seen(q_seen_s)
  );

  typedef struct {
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;
    logic [7:0] wrap_cnt;
    logic [3:0] q_seen;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: 0 idle, 1 acquiring, 2 locked.
  int m_state = 0, m_good = 0, m_p = 0, m_errc = 0, m_errs = 0, m_wrap = 0;
  int m_err = 0;
  logic [3:0] cnt = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic [3:0] q, input logic c);
    exp_t e;
    logic good;
    if (r) begin
      m_state = 0; m_good = 0; m_p = 0; m_err = 0; m_errc = 0; m_errs = 0; m_wrap = 0;
    end else begin
      good  = (int'(q) == (m_p + 1) % 16) && (c == (q == 4'hF));
      m_err = 0;
      if (m_state == 0) begin
        m_state = 1;
        m_good  = 0;
      end else if (m_state == 1) begin
        if (good) begin
          m_good++;
          if (m_good == LockN) m_state = 2;
        end else begin
          m_good = 0;
        end
      end else begin
        if (good) begin
          if (m_p == 15 && q == 4'h0) m_wrap = (m_wrap + 1) % 256;
        end else begin
          m_err = 1;
          if (m_errc < 255) m_errc++;
          if (m_errs < 3) m_errs++;
          m_state = 1;
          m_good  = 0;
        end
      end
      m_p = int'(q);
    end
    e.locked    = (m_state == 2);
    e.err       = (m_err != 0);
    e.err_cnt   = 8'(m_errc);
    e.err_cnt_s = 2'(m_errs);
    e.wrap_cnt  = 8'(m_wrap);
    e.q_seen    = 4'(m_p);
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic c);
    @(negedge clk);
    rst = r;
    {qd, qc, qb, qa} = q;
    rc = c;
    model(r, q, c);
  endtask

  // Free-running counter with correct Rc.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, cnt, cnt == 4'hF);
      cnt = cnt + 4'd1;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("locked", 32'(locked), 32'(e.locked));
      check("err", 32'(err), 32'(e.err));
      check("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
      check("wrap_cnt", 32'(wrap_cnt), 32'(e.wrap_cnt));
      check("q_seen", 32'(q_seen), 32'(e.q_seen));
      check("sat_locked", 32'(locked_s), 32'(e.locked));
      check("sat_err", 32'(err_s), 32'(e.err));
      check("sat_err_cnt", 32'(err_cnt_s), 32'(e.err_cnt_s));
      check("sat_wrap_cnt", 32'(wrap_cnt_s), 32'(e.wrap_cnt));
    end
  end

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset for two cycles.
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    settle();
    check("rst_outputs", {locked, err, err_cnt, wrap_cnt, q_seen}, 32'd0);

    // Clean run: lock after the 5th edge, then four wraps in 64 edges.
    cnt = 4'd0;
    run(4);
    settle();
    check("clean_not_locked_e4", 32'(locked), 32'd0);
    run(1);
    settle();
    check("clean_locked_e5", 32'(locked), 32'd1);
    run(64);
    settle();
    check("clean_wrap_cnt", 32'(wrap_cnt), 32'd4);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);

    // Skip 5 -> 7 while locked, relock after 8, 9, 10, 11.
    run(1);
    cnt = 4'd7;
    run(1);
    settle();
    check("skip_err", 32'(err), 32'd1);
    check("skip_err_cnt", 32'(err_cnt), 32'd1);
    check("skip_locked", 32'(locked), 32'd0);
    run(3);
    settle();
    check("skip_err_one_cycle", 32'(err), 32'd0);
    check("skip_not_relocked", 32'(locked), 32'd0);
    run(1);
    settle();
    check("skip_relocked", 32'(locked), 32'd1);

    // Rc stuck low: samples 12..43 hold two terminal counts, so two faults, no wraps.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, cnt, 1'b0);
      cnt = cnt + 4'd1;
    end
    settle();
    check("rc_stuck_err_cnt", 32'(err_cnt), 32'd3);
    check("rc_stuck_wrap_cnt", 32'(wrap_cnt), 32'd4);

    // Stall at 3 during acquisition: no error, lock after 4, 5, 6, 7.
    step(1'b1, 4'd0, 1'b0);
    cnt = 4'd0;
    run(4);
    step(1'b0, 4'd3, 1'b0);
    step(1'b0, 4'd3, 1'b0);
    run(3);
    settle();
    check("stall_not_locked", 32'(locked), 32'd0);
    check("stall_err_cnt", 32'(err_cnt), 32'd0);
    run(1);
    settle();
    check("stall_locked", 32'(locked), 32'd1);

    // Repeated skips: the 2-bit counter saturates at 3, err keeps pulsing.
    for (int k = 0; k < 5; k++) begin
      run(1);
      cnt = cnt + 4'd1;
      run(1);
      settle();
      check("sat_err_pulse", 32'(err_s), 32'd1);
      check("sat_err_cnt_seq", 32'(err_cnt_s), 32'(sat_exp[k]));
      check("wide_err_cnt_seq", 32'(err_cnt), 32'(k + 1));
      run(LockN);
    end

    // Reset mid-lock with wrap_cnt = 2 and err_cnt = 1.
    step(1'b1, 4'd0, 1'b0);
    cnt = 4'd0;
    run(6);
    cnt = 4'd7;
    run(27);
    settle();
    check("midlock_wrap_cnt", 32'(wrap_cnt), 32'd2);
    check("midlock_err_cnt", 32'(err_cnt), 32'd1);
    check("midlock_locked", 32'(locked), 32'd1);
    step(1'b1, cnt, 1'b0);
    settle();
    check("midlock_rst_outputs", {locked, err, err_cnt, wrap_cnt, q_seen}, 32'd0);
    run(4);
    settle();
    check("midlock_not_relocked", 32'(locked), 32'd0);
    run(1);
    settle();
    check("midlock_relocked", 32'(locked), 32'd1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
